// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pkg
//  Purpose  : Shared register-file constants, index type and the write-set
//             decode used by the scoreboard and the hazard/forwarding logic.
//  Contents : NUM_REGS, IDX_W, REG_ZERO, REG_LINK, regidx_t, write_set()
//  Revision : 1.0  initial release
// ============================================================================
package reg_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_LINK = 31;

  typedef logic [IDX_W-1:0] regidx_t;

  // One-hot-or-two mask of registers written by one instruction.
  // r0 is never part of the set; dest==r31 together with link collapses
  // into a single write because both land on the same bit.
  function automatic logic [NUM_REGS-1:0] write_set(
    input logic    wr,
    input regidx_t dest,
    input logic    link
  );
    logic [NUM_REGS-1:0] s;
    s = '0;
    if (wr && (dest != regidx_t'(REG_ZERO))) begin
      s[dest] = 1'b1;
    end
    if (link) begin
      s[REG_LINK] = 1'b1;
    end
    return s;
  endfunction

endpackage : reg_pkg
`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sb_counter
//  Purpose  : In-flight write counter for one architectural register.
//  Ports    : clk, rst        clock / async active-high reset
//             inc             an accepted issue targets this register
//             dec             write-back targets this register
//             clr             synchronous clear (flush), overrides inc/dec
//             count           current number of writes in flight
//             nonzero         count != 0
//             full            count == MAX_INFLIGHT
//             underflow       write-back arrived with nothing in flight
//  Revision : 1.0  initial release
// ============================================================================
module sb_counter #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);

  // The issue side never increments a full counter (the top stalls it), so
  // no overflow guard is needed on the increment path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !dec) begin
      r_count <= r_count + CNT_W'(1);
    end else if (dec && !inc && !w_zero) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count     = r_count;
  assign nonzero   = !w_zero;
  assign full      = (r_count == CNT_W'(MAX_INFLIGHT));
  // A simultaneous issue absorbs the write-back, so that case is not an error.
  assign underflow = dec && !inc && w_zero;

endmodule : sb_counter
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Read-side hazard guard for the 32x32 register file. Counts
//             issued-but-not-written-back writes per destination register and
//             stalls decode when a source operand would read stale data.
//  Ports    : clk, rst                      clock / async active-high reset
//             issue_valid/wr/dest/link      instruction presented by decode
//             use_rs/src_rs, use_rt/src_rt  source operands read by it
//             wb_valid/wb_dest/wb_link      write-back stage writes
//             flush                         synchronous clear of all counts
//             stall                         issue not accepted this cycle
//             busy_rs/busy_rt               source has a pending write
//             pending_mask                  bit i = register i in flight
//             err_underflow                 sticky write-back-without-issue
//  Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NUM_REGS     = reg_pkg::NUM_REGS,
  parameter int IDX_W        = reg_pkg::IDX_W,
  parameter int CNT_W        = 2,
  // Must not exceed 2**CNT_W-1 or the counter would wrap.
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [IDX_W-1:0]    issue_dest,
  input  logic                issue_link,
  input  logic                use_rs,
  input  logic [IDX_W-1:0]    src_rs,
  input  logic                use_rt,
  input  logic [IDX_W-1:0]    src_rt,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_dest,
  input  logic                wb_link,
  input  logic                flush,
  output logic                stall,
  output logic                busy_rs,
  output logic                busy_rt,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                err_underflow
);

  import reg_pkg::*;

  logic [NUM_REGS-1:0] w_iss_set;
  logic [NUM_REGS-1:0] w_wb_set;
  logic [NUM_REGS-1:0] w_nonzero;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_unf;
  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic                w_sat;
  logic                w_accept;
  logic                w_unused;
  logic                r_err;

  assign w_iss_set = write_set(issue_wr, regidx_t'(issue_dest), issue_link);
  assign w_wb_set  = write_set(wb_valid, regidx_t'(wb_dest), wb_link);

  // r0 is hard-wired: never pending, never full, never underflows.
  assign w_cnt[0]     = '0;
  assign w_nonzero[0] = 1'b0;
  assign w_full[0]    = 1'b0;
  assign w_unf[0]     = 1'b0;

  // Bit 0 of the write-back set is always clear by construction.
  assign w_unused = ^{w_wb_set[0], 1'b0};

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
      sb_counter #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
      ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_accept & w_iss_set[gi]),
        .dec       (w_wb_set[gi]),
        .clr       (flush),
        .count     (w_cnt[gi]),
        .nonzero   (w_nonzero[gi]),
        .full      (w_full[gi]),
        .underflow (w_unf[gi])
      );
    end
  endgenerate

  // No bypass: a register being written back this cycle still reads busy,
  // because the counter only drops at the clock edge.
  assign busy_rs = use_rs & (w_cnt[src_rs] != '0);
  assign busy_rt = use_rt & (w_cnt[src_rt] != '0);

  // A same-cycle write-back to a full register does not make room; the
  // decision uses registered counts only.
  assign w_sat    = |(w_iss_set & w_full);
  assign stall    = issue_valid & (busy_rs | busy_rt | w_sat);
  assign w_accept = issue_valid & ~stall;

  // Sticky until reset; flush intentionally leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (|w_unf) begin
      r_err <= 1'b1;
    end
  end

  assign pending_mask  = w_nonzero;
  assign err_underflow = r_err;

endmodule : reg_scoreboard
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Purpose  : Self-checking bench for reg_scoreboard: directed scenarios
//             followed by randomized traffic, all checked against a
//             count-per-register reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr, issue_link;
  logic [4:0]  issue_dest;
  logic        use_rs, use_rt;
  logic [4:0]  src_rs, src_rt;
  logic        wb_valid, wb_link;
  logic [4:0]  wb_dest;
  logic        flush;
  logic        stall, busy_rs, busy_rt, err_underflow;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_wr      (issue_wr),
    .issue_dest    (issue_dest),
    .issue_link    (issue_link),
    .use_rs        (use_rs),
    .src_rs        (src_rs),
    .use_rt        (use_rt),
    .src_rt        (src_rt),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .wb_link       (wb_link),
    .flush         (flush),
    .stall         (stall),
    .busy_rs       (busy_rs),
    .busy_rt       (busy_rt),
    .pending_mask  (pending_mask),
    .err_underflow (err_underflow)
  );

  // Reference model: number of writes in flight per register.
  int   cnt [32];
  bit   m_err;
  logic exp_stall, exp_brs, exp_brt;
  logic [31:0] exp_mask;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    m_err = 1'b0;
  endfunction

  // Destinations an instruction writes, as a membership table.
  function automatic void dest_set(input logic wr, input logic [4:0] d,
                                   input logic lnk, output bit s [32]);
    for (int r = 0; r < 32; r++) s[r] = 1'b0;
    if (wr && d != 0) s[d] = 1'b1;
    if (lnk) s[31] = 1'b1;
  endfunction

  function automatic void model_eval();
    bit iss [32];
    bit sat;
    dest_set(issue_wr, issue_dest, issue_link, iss);
    sat = 1'b0;
    for (int r = 1; r < 32; r++) if (iss[r] && cnt[r] >= 3) sat = 1'b1;
    exp_brs = use_rs && (src_rs != 0) && (cnt[src_rs] > 0);
    exp_brt = use_rt && (src_rt != 0) && (cnt[src_rt] > 0);
    exp_stall = issue_valid && (exp_brs || exp_brt || sat);
    exp_mask = '0;
    for (int r = 1; r < 32; r++) if (cnt[r] > 0) exp_mask[r] = 1'b1;
  endfunction

  function automatic void model_step();
    bit iss [32];
    bit wbs [32];
    bit acc;
    acc = issue_valid && !exp_stall;
    dest_set(issue_wr, issue_dest, issue_link, iss);
    dest_set(wb_valid, wb_dest, wb_link, wbs);
    for (int r = 1; r < 32; r++) begin
      bit inc;
      inc = acc && iss[r];
      if (inc && !wbs[r]) cnt[r] = cnt[r] + 1;
      else if (wbs[r] && !inc) begin
        if (cnt[r] == 0) m_err = 1'b1;
        else cnt[r] = cnt[r] - 1;
      end
    end
    if (flush) for (int r = 0; r < 32; r++) cnt[r] = 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    model_eval();
    check("pending_mask", pending_mask, exp_mask);
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    check("busy_rs", {31'b0, busy_rs}, {31'b0, exp_brs});
    check("busy_rt", {31'b0, busy_rt}, {31'b0, exp_brt});
    check("err_underflow", {31'b0, err_underflow}, {31'b0, m_err});
  endtask

  // Check combinational outputs mid-cycle, then let the edge happen.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_dest = 0; issue_link = 0;
    use_rs = 0; src_rs = 0; use_rt = 0; src_rt = 0;
    wb_valid = 0; wb_dest = 0; wb_link = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] d);
    idle();
    issue_valid = 1; issue_wr = 1; issue_dest = d;
  endtask

  task automatic wb(input logic [4:0] d);
    idle();
    wb_valid = 1; wb_dest = d;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // Issue r5 appears in pending_mask the next cycle.
    issue(5); tick();
    check("mask_r5", pending_mask, 32'h0000_0020);

    // RAW on r5; the write-back cycle itself still stalls.
    issue(6); use_rs = 1; src_rs = 5; #1;
    check("raw_stall", {31'b0, stall}, 32'd1);
    check("raw_busy_rs", {31'b0, busy_rs}, 32'd1);
    tick();
    issue(6); use_rs = 1; src_rs = 5; wb_valid = 1; wb_dest = 5; #1;
    check("wb_cycle_stall", {31'b0, stall}, 32'd1);
    tick();
    issue(6); use_rs = 1; src_rs = 5; #1;
    check("after_wb_stall", {31'b0, stall}, 32'd0);
    tick();

    // Simultaneous issue and write-back to r7 keeps the count.
    issue(7); tick();
    issue(7); wb_valid = 1; wb_dest = 7; tick();
    idle(); #1;
    check("r7_held", {31'b0, pending_mask[7]}, 32'd1);
    wb(7); tick();
    wb(6); tick();
    idle(); tick();

    // r0 never tracked; dest 31 + link is one write.
    issue(0); tick();
    issue(3); use_rs = 1; src_rs = 0; use_rt = 1; src_rt = 0; tick();
    wb(3); tick();
    issue(31); issue_link = 1; tick();
    idle(); wb_link = 1; tick();
    idle(); #1;
    check("link_single", {31'b0, pending_mask[31]}, 32'd0);
    tick();

    // Saturation at three in flight.
    issue(9); tick(); issue(9); tick(); issue(9); tick();
    issue(9); #1;
    check("sat_stall", {31'b0, stall}, 32'd1);
    tick();
    issue(9); wb_valid = 1; wb_dest = 9; tick();
    issue(9); #1;
    check("retry_accept", {31'b0, stall}, 32'd0);
    tick();
    wb(9); tick(); wb(9); tick(); wb(9); tick();

    // Underflow is sticky; flush clears counts only.
    wb(2); tick();
    idle(); #1;
    check("underflow_set", {31'b0, err_underflow}, 32'd1);
    issue(3); tick(); issue(4); tick(); issue(8); tick();
    idle(); flush = 1; tick();
    idle(); #1;
    check("flush_mask", pending_mask, 32'd0);
    check("flush_keeps_err", {31'b0, err_underflow}, 32'd1);
    tick();

    // Asynchronous reset mid-cycle with counts in flight.
    issue(5); tick(); issue(8); tick();
    issue(10); use_rs = 1; src_rs = 5; #1;
    check("pre_rst_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1; #1;
    model_reset();
    check("rst_mask", pending_mask, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_err", {31'b0, err_underflow}, 32'd0);
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(5); tick();
    check("post_rst_r5", pending_mask, 32'h0000_0020);
    idle(); wb(5); tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int q[$];
      int mode;
      if (i == 300) begin
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
      end
      idle();
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr    = ($urandom_range(0, 3) != 0);
      issue_dest  = pick_reg();
      issue_link  = ($urandom_range(0, 7) == 0);
      use_rs      = $urandom_range(0, 1) != 0;
      src_rs      = pick_reg();
      use_rt      = $urandom_range(0, 1) != 0;
      src_rt      = pick_reg();
      for (int r = 1; r < 31; r++) if (cnt[r] > 0) q.push_back(r);
      mode = int'($urandom_range(0, 19));
      if (mode < 8 && q.size() > 0) begin
        wb_valid = 1;
        wb_dest  = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if (mode == 8) begin
        wb_valid = 1;
        wb_dest  = 5'($urandom_range(0, 31));
      end
      wb_link = (cnt[31] > 0) && ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 63) == 0);
      tick();
    end

    idle(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_reg_scoreboard
`default_nettype wire
